// File: rtl/rv_pkg.sv
// Shared integer-pipeline constants for the register-file slice.
//   XLEN, NREG, AW : register width, register count, register address width
//   MAX_LD         : outstanding-load capacity of the load scoreboard
//   REG_ZERO       : address of the hardwired-zero register x0
//   wb_sel_e       : writeback mux select; a load writeback is sel == WB_MEM
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int AW     = 5;
  localparam int MAX_LD = 4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  // Upstream helper: the writeback completes a load when memory data is selected.
  function automatic logic is_load_sel(input wb_sel_e sel);
    return sel == WB_MEM;
  endfunction

endpackage

// File: rtl/ld_scoreboard.sv
// Load scoreboard: tracks which registers await an outstanding load and how
// many loads are in flight.
//   clk, rst_n              : clock, asynchronous active-low reset
//   ld_issue, ld_rd         : a load with destination ld_rd leaves decode
//   wb_en, wb_is_load,
//   wb_addr                 : writeback qualifiers; a load writeback clears busy
//   rs1_addr/rs1_used,
//   rs2_addr/rs2_used       : decode-stage source operands
//   stall                   : a used source register is waiting on a load
//   ld_full                 : in-flight load count has reached MAX_LD
//   busy                    : per-register pending-load flags
module ld_scoreboard #(
  parameter int NREG   = rv_pkg::NREG,
  parameter int AW     = rv_pkg::AW,
  parameter int MAX_LD = rv_pkg::MAX_LD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_issue,
  input  logic [AW-1:0]   ld_rd,
  input  logic            wb_en,
  input  logic            wb_is_load,
  input  logic [AW-1:0]   wb_addr,
  input  logic [AW-1:0]   rs1_addr,
  input  logic            rs1_used,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            rs2_used,
  output logic            stall,
  output logic            ld_full,
  output logic [NREG-1:0] busy
);

  import rv_pkg::*;

  localparam int            CW      = $clog2(MAX_LD + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LD);
  localparam logic [AW-1:0] ZERO_A  = AW'(REG_ZERO);

  logic [CW-1:0]   ld_cnt;
  logic [CW-1:0]   ld_cnt_nxt;
  logic [NREG-1:0] busy_nxt;
  logic            ld_set;
  logic            ld_clr;
  logic            clr_hit1;
  logic            clr_hit2;

  assign ld_set = ld_issue;
  assign ld_clr = wb_en && wb_is_load;

  // Counter saturates at both ends; an issue and a return in the same cycle cancel.
  always_comb begin
    ld_cnt_nxt = ld_cnt;
    if (ld_set && !ld_clr) begin
      if (ld_cnt != CNT_MAX) ld_cnt_nxt = ld_cnt + 1'b1;
    end else if (ld_clr && !ld_set) begin
      if (ld_cnt != '0) ld_cnt_nxt = ld_cnt - 1'b1;
    end
  end

  // Clear first, then set, so a newly issued load to the same register wins.
  always_comb begin
    busy_nxt = busy;
    if (ld_clr && wb_addr != ZERO_A) busy_nxt[wb_addr] = 1'b0;
    if (ld_set && ld_rd != ZERO_A)   busy_nxt[ld_rd]   = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt <= '0;
      busy   <= '0;
    end else begin
      ld_cnt <= ld_cnt_nxt;
      busy   <= busy_nxt;
    end
  end

  // A returning load releases its consumer in the same cycle; the bypass carries the data.
  assign clr_hit1 = ld_clr && (wb_addr == rs1_addr);
  assign clr_hit2 = ld_clr && (wb_addr == rs2_addr);

  assign stall = (rs1_used && rs1_addr != ZERO_A && busy[rs1_addr] && !clr_hit1)
               | (rs2_used && rs2_addr != ZERO_A && busy[rs2_addr] && !clr_hit2);

  assign ld_full = (ld_cnt == CNT_MAX);

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(ld_issue && ld_full))
        else $error("ld_scoreboard: load issued while scoreboard is full");
      assert (!(ld_clr && ld_cnt == '0))
        else $error("ld_scoreboard: load writeback with no outstanding load");
    end
  end
`endif

endmodule

// File: rtl/wb_regfile.sv
// Architectural integer register file fed by the writeback mux.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   rs1_addr/rs1_used/rs1_data : decode read port 1 (combinational, write-bypassed)
//   rs2_addr/rs2_used/rs2_data : decode read port 2
//   wb_en, wb_addr, wb_data    : one writeback write per cycle; x0 writes dropped
//   wb_is_load                 : the writeback returns a load
//   ld_issue, ld_rd            : a load leaves decode with destination ld_rd
//   stall                      : decode must hold for a pending load
//   ld_full                    : decode must not issue another load
module wb_regfile #(
  parameter int XLEN   = rv_pkg::XLEN,
  parameter int NREG   = rv_pkg::NREG,
  parameter int AW     = rv_pkg::AW,
  parameter int MAX_LD = rv_pkg::MAX_LD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic            rs1_used,
  output logic [XLEN-1:0] rs1_data,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            rs2_used,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            wb_is_load,
  input  logic            ld_issue,
  input  logic [AW-1:0]   ld_rd,
  output logic            stall,
  output logic            ld_full
);

  import rv_pkg::*;

  localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en && wb_addr != ZERO_A) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // x0 reads zero even when a write to it is on the bus this cycle.
  assign rs1_data = (rs1_addr == ZERO_A)                 ? '0      :
                    (wb_en && wb_addr == rs1_addr)       ? wb_data :
                                                           regs[rs1_addr];
  assign rs2_data = (rs2_addr == ZERO_A)                 ? '0      :
                    (wb_en && wb_addr == rs2_addr)       ? wb_data :
                                                           regs[rs2_addr];

  ld_scoreboard #(
    .NREG   (NREG),
    .AW     (AW),
    .MAX_LD (MAX_LD)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_issue   (ld_issue),
    .ld_rd      (ld_rd),
    .wb_en      (wb_en),
    .wb_is_load (wb_is_load),
    .wb_addr    (wb_addr),
    .rs1_addr   (rs1_addr),
    .rs1_used   (rs1_used),
    .rs2_addr   (rs2_addr),
    .rs2_used   (rs2_used),
    .stall      (stall),
    .ld_full    (ld_full),
    .busy       (busy)
  );

`ifndef SYNTHESIS
  // A non-load write to a register with a pending load means the load will later overwrite it.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(wb_en && !wb_is_load && wb_addr != ZERO_A && busy[wb_addr]))
        else $error("wb_regfile: non-load writeback to register with pending load");
    end
  end
`endif

endmodule
